// File: rtl/line_memory_responder_pkg.sv
// Shared constants and state type for the line-organised memory responder.
package line_memory_responder_pkg;

    localparam int unsigned LINE_W     = 256;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_OFS_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/line_mem_array.sv
// Synchronous single-port DEPTH x LINE_W line store with registered read; contents are never reset.
module line_mem_array
    import line_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned IDX_W = 9
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory_responder.sv
// Main-memory model behind the data cache: fixed-latency request/ack handshake over a line array.
module line_memory_responder
    import line_memory_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned IDX_W   = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_ack_o
);

    localparam int unsigned CNT_W = 8;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_we_q, req_we_d;
    logic [IDX_W-1:0]  req_idx_q, req_idx_d;
    logic [LINE_W-1:0] req_data_q, req_data_d;
    logic              ack_q, ack_d;
    logic              rd_seen_q, rd_seen_d;

    logic              done;
    logic              done_we;
    logic [IDX_W-1:0]  in_idx;
    logic              arr_we, arr_re;
    logic [IDX_W-1:0]  arr_idx;
    logic [LINE_W-1:0] arr_wdata, arr_rdata;
    logic              unused_addr;

    assign in_idx      = mem_addr_i[IDX_W+LINE_OFS_W-1:LINE_OFS_W];
    assign unused_addr = ^{mem_addr_i[ADDR_W-1:IDX_W+LINE_OFS_W], mem_addr_i[LINE_OFS_W-1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_we_d   = req_we_q;
        req_idx_d  = req_idx_q;
        req_data_d = req_data_q;
        ack_d      = 1'b0;
        rd_seen_d  = rd_seen_q;
        done       = 1'b0;
        done_we    = req_we_q;
        arr_idx    = req_idx_q;
        arr_wdata  = req_data_q;
        arr_we     = 1'b0;
        arr_re     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_enable_i) begin
                    req_we_d   = mem_write_i;
                    req_idx_d  = in_idx;
                    req_data_d = mem_data_i;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        done      = 1'b1;
                        done_we   = mem_write_i;
                        arr_idx   = in_idx;
                        arr_wdata = mem_data_i;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!mem_enable_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The array commits on the same edge that raises ack; gated so an edge under reset never writes.
        if (done) begin
            state_d = ACK;
            ack_d   = 1'b1;
            arr_we  = done_we & rst_i;
            arr_re  = ~done_we & rst_i;
            if (!done_we) begin
                rd_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_we_q   <= 1'b0;
            req_idx_q  <= '0;
            req_data_q <= '0;
            ack_q      <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_we_q   <= req_we_d;
            req_idx_q  <= req_idx_d;
            req_data_q <= req_data_d;
            ack_q      <= ack_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    line_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .idx_i   (arr_idx),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    // The read register holds the last read line; the reset flag masks it to zero until a read lands.
    assign mem_data_o = rd_seen_q ? arr_rdata : '0;
    assign mem_ack_o  = ack_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Randomized bench for line_memory_responder against a timestamp-based memory model.
module tb_line_memory_responder;

    localparam int unsigned LAT   = 10;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned IDX_W = 9;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         mem_enable_i = 1'b0;
    logic         mem_write_i = 1'b0;
    logic [31:0]  mem_addr_i = '0;
    logic [255:0] mem_data_i = '0;
    logic [255:0] mem_data_o;
    logic         mem_ack_o;

    int n_cmp = 0;
    int n_bad = 0;

    line_memory_responder #(
        .LATENCY (LAT),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_enable_i (mem_enable_i),
        .mem_write_i  (mem_write_i),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .mem_data_o   (mem_data_o),
        .mem_ack_o    (mem_ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: a request is due LAT edges after the edge that samples it; memory is a sparse array.
    logic [255:0] model_mem [int];
    bit           busy;
    int           edge_no = 0;
    int           due;
    int           last_ack = -100;
    bit           r_we;
    int           r_idx;
    logic [255:0] r_data;
    bit           m_ack;
    logic [255:0] m_data;
    bit           m_known;

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    task automatic model_complete();
        busy     = 0;
        last_ack = edge_no;
        m_ack    = 1;
        if (r_we) begin
            model_mem[r_idx] = r_data;
        end else if (model_mem.exists(r_idx)) begin
            m_data  = model_mem[r_idx];
            m_known = 1;
        end else begin
            m_known = 0;
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            busy     = 0;
            m_ack    = 0;
            m_data   = '0;
            m_known  = 1;
            last_ack = -100;
            chk("reset_ack", {255'd0, mem_ack_o}, '0);
            chk("reset_data", mem_data_o, '0);
        end else begin
            chk("ack", {255'd0, mem_ack_o}, {255'd0, m_ack});
            if (m_known) chk("data", mem_data_o, m_data);
            edge_no++;
            m_ack = 0;
            if (busy) begin
                if (!mem_enable_i) busy = 0;
                else if (edge_no == due) model_complete();
            end else if (mem_enable_i && edge_no >= last_ack + 2) begin
                r_we   = mem_write_i;
                r_idx  = line_of(mem_addr_i);
                r_data = mem_data_i;
                if (LAT == 1) model_complete();
                else begin
                    busy = 1;
                    due  = edge_no + LAT;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic wait_ack(output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (!mem_ack_o && edges < 100);
        n_cmp++;
        if (!mem_ack_o) begin
            n_bad++;
            $display("FAIL ack_timeout: got no ack after %0d edges, want ack", edges);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] addr, input logic [255:0] d, output int lat);
        mem_enable_i = 1'b1;
        mem_write_i  = we;
        mem_addr_i   = addr;
        mem_data_i   = d;
        wait_ack(lat);
        mem_enable_i = 1'b0;
        mem_write_i  = 1'($urandom);
        mem_addr_i   = $urandom;
        mem_data_i   = rnd_line();
    endtask

    logic [255:0] deadbeef, la, lb, lc, ld, le, lf;
    int lat;
    logic [31:0] pool [8];

    initial begin
        deadbeef = {8{32'hDEAD_BEEF}};
        la = rnd_line(); lb = rnd_line(); lc = rnd_line();
        ld = rnd_line(); le = rnd_line(); lf = rnd_line();

        idle(3);
        rst_i = 1'b1;
        idle(20);
        chk("idle_ack", {255'd0, mem_ack_o}, '0);
        chk("idle_data", mem_data_o, '0);

        xfer(1'b1, 32'h0000_0040, deadbeef, lat);
        chk("write_latency", 256'(lat), 256'(LAT + 1));
        step();
        chk("ack_one_cycle", {255'd0, mem_ack_o}, '0);
        idle(2);
        xfer(1'b0, 32'h0000_0040, 256'd0, lat);
        chk("read_latency", 256'(lat), 256'(LAT + 1));
        chk("read_deadbeef", mem_data_o, deadbeef);
        idle(2);

        xfer(1'b1, 32'h0000_0020, la, lat); idle(2);
        xfer(1'b0, 32'h0000_003C, '0, lat);
        chk("offset_read", mem_data_o, la);
        idle(2);
        xfer(1'b1, 32'h0000_4000, lb, lat); idle(2);
        xfer(1'b0, 32'h0000_0000, '0, lat);
        chk("wrap_read", mem_data_o, lb);
        idle(2);

        xfer(1'b1, 32'h0000_0080, le, lat); idle(2);
        mem_enable_i = 1'b1; mem_write_i = 1'b1; mem_addr_i = 32'h80; mem_data_i = lc;
        idle(5);
        mem_enable_i = 1'b0;
        idle(15);
        xfer(1'b0, 32'h0000_0080, '0, lat);
        chk("abort_read", mem_data_o, le);
        idle(2);

        xfer(1'b1, 32'h0000_0100, lf, lat); idle(2);
        mem_enable_i = 1'b1; mem_write_i = 1'b0; mem_addr_i = 32'h0000_0020;
        wait_ack(lat);
        chk("b2b_first", mem_data_o, la);
        mem_addr_i = 32'h0000_0100;
        idle(4);
        mem_addr_i = 32'h0000_0040;
        wait_ack(lat);
        chk("b2b_second", mem_data_o, lf);
        mem_enable_i = 1'b0;
        idle(2);

        xfer(1'b1, 32'h0000_00C0, le, lat); idle(2);
        mem_enable_i = 1'b1; mem_write_i = 1'b1; mem_addr_i = 32'hC0; mem_data_i = ld;
        idle(3);
        rst_i = 1'b0; mem_enable_i = 1'b0;
        idle(3);
        rst_i = 1'b1;
        chk("post_reset_data", mem_data_o, '0);
        idle(2);
        xfer(1'b0, 32'h0000_00C0, '0, lat);
        chk("reset_abort_read", mem_data_o, le);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            pool[i] = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'd0, 9'($urandom), 5'($urandom)};
            xfer(1'b1, pool[i], rnd_line(), lat);
            idle(2);
        end
        for (int it = 0; it < 150; it++) begin
            int op = $urandom_range(0, 9);
            logic [31:0] a = pool[$urandom_range(0, 7)];
            a[4:0] = 5'($urandom);
            if (op < 7) begin
                xfer(1'($urandom), a, rnd_line(), lat);
                idle($urandom_range(0, 3));
            end else if (op < 9) begin
                mem_enable_i = 1'b1; mem_write_i = 1'($urandom); mem_addr_i = a; mem_data_i = rnd_line();
                idle($urandom_range(1, 9));
                mem_enable_i = 1'b0;
                idle(2);
            end else begin
                mem_enable_i = 1'b1; mem_write_i = 1'($urandom); mem_addr_i = a; mem_data_i = rnd_line();
                idle($urandom_range(1, 8));
                rst_i = 1'b0; mem_enable_i = 1'b0;
                idle(2);
                rst_i = 1'b1;
                idle(1);
            end
        end

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
